// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the RAM B-port arbiter.
// State codes, size codes and requester ids.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic REQ_IFU = 1'b0;
  localparam logic REQ_LSU = 1'b1;

  // Index of the last byte of a store; reserved size acts as word.
  function automatic logic [1:0] last_idx(
    input logic [1:0] size
  );
    logic [1:0] r;
    r = 2'd3;
    unique case (size)
      SZ_B:    r = 2'd0;
      SZ_H:    r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request/response and RAM B-port bundle.
// slave = arbiter side, master = requesters + RAM.
interface mem_port_arbiter_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                  ifu_req_valid;
  logic [ADDR_WIDTH-1:0] ifu_req_addr;
  logic                  ifu_req_ready;
  logic                  ifu_rsp_valid;
  logic [DATA_WIDTH-1:0] ifu_rsp_data;

  logic                  lsu_req_valid;
  logic                  lsu_req_we;
  logic [1:0]            lsu_req_size;
  logic [ADDR_WIDTH-1:0] lsu_req_addr;
  logic [DATA_WIDTH-1:0] lsu_req_wdata;
  logic                  lsu_req_ready;
  logic                  lsu_rsp_valid;
  logic [DATA_WIDTH-1:0] lsu_rsp_data;

  logic                  ram_we;
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [7:0]            ram_din;
  logic [DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  ifu_req_valid,
    input  ifu_req_addr,
    output ifu_req_ready,
    output ifu_rsp_valid,
    output ifu_rsp_data,
    input  lsu_req_valid,
    input  lsu_req_we,
    input  lsu_req_size,
    input  lsu_req_addr,
    input  lsu_req_wdata,
    output lsu_req_ready,
    output lsu_rsp_valid,
    output lsu_rsp_data,
    output ram_we,
    output ram_addr,
    output ram_din,
    input  ram_dout
  );

  modport master (
    output ifu_req_valid,
    output ifu_req_addr,
    input  ifu_req_ready,
    input  ifu_rsp_valid,
    input  ifu_rsp_data,
    output lsu_req_valid,
    output lsu_req_we,
    output lsu_req_size,
    output lsu_req_addr,
    output lsu_req_wdata,
    input  lsu_req_ready,
    input  lsu_rsp_valid,
    input  lsu_rsp_data,
    input  ram_we,
    input  ram_addr,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/mem_port_arbiter_rr_arbiter2.sv
// Two-way round-robin grant.
// Ties go to whoever did not win last.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_grant;

  // Grant decode: single requester wins, tie goes to the other side.
  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_grant == REQ_LSU) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember the winner of every accepted grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= REQ_LSU;
    end else if (en && (gnt != 2'b00)) begin
      last_grant <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the RAM B port between IFU and LSU.
// Word reads take 1 cycle; stores go out one byte per cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  state_t                state;
  logic                  rid;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [1:0]            k;
  logic [1:0]            last_k;

  logic                  idle;
  logic [1:0]            req;
  logic [1:0]            gnt;
  logic                  wr_last;

  // Grants are only offered while idle and out of reset.
  assign idle = (state == ST_IDLE) && !rst;
  assign req  = idle ? {bus.lsu_req_valid, bus.ifu_req_valid}
                     : 2'b00;

  rr_arbiter2 u_arb (
    .clk (clk),
    .rst (rst),
    .req (req),
    .en  (idle),
    .gnt (gnt)
  );

  assign bus.ifu_req_ready = gnt[0];
  assign bus.lsu_req_ready = gnt[1];

  assign wr_last = (state == ST_WRITE) && (k == last_k);

  // Control FSM plus store byte sequencer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      rid     <= REQ_IFU;
      addr_q  <= '0;
      wdata_q <= '0;
      k       <= 2'd0;
      last_k  <= 2'd0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (gnt[0]) begin
            rid   <= REQ_IFU;
            state <= ST_READ;
          end else if (gnt[1]) begin
            rid <= REQ_LSU;
            if (bus.lsu_req_we) begin
              addr_q  <= bus.lsu_req_addr;
              wdata_q <= bus.lsu_req_wdata;
              last_k  <= last_idx(bus.lsu_req_size);
              k       <= 2'd0;
              state   <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          state <= ST_IDLE;
        end
        ST_WRITE: begin
          if (k == last_k) begin
            state <= ST_IDLE;
          end else begin
            k <= k + 2'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // RAM port drive: read address when idle, byte writes in WRITE.
  always_comb begin
    bus.ram_we   = 1'b0;
    bus.ram_addr = '0;
    bus.ram_din  = 8'h00;
    unique case (state)
      ST_IDLE: begin
        if (gnt[0]) begin
          bus.ram_addr = bus.ifu_req_addr;
        end else if (gnt[1] && !bus.lsu_req_we) begin
          bus.ram_addr = bus.lsu_req_addr;
        end
      end
      ST_WRITE: begin
        bus.ram_we   = 1'b1;
        bus.ram_addr = addr_q + ADDR_WIDTH'(k);
        unique case (k)
          2'd0:    bus.ram_din = wdata_q[7:0];
          2'd1:    bus.ram_din = wdata_q[15:8];
          2'd2:    bus.ram_din = wdata_q[23:16];
          default: bus.ram_din = wdata_q[31:24];
        endcase
      end
      default: begin
        bus.ram_we = 1'b0;
      end
    endcase
  end

  // Responses: read data straight from RAM, zero otherwise.
  always_comb begin
    bus.ifu_rsp_valid = 1'b0;
    bus.ifu_rsp_data  = '0;
    bus.lsu_rsp_valid = wr_last;
    bus.lsu_rsp_data  = '0;
    if (state == ST_READ) begin
      if (rid == REQ_IFU) begin
        bus.ifu_rsp_valid = 1'b1;
        bus.ifu_rsp_data  = bus.ram_dout;
      end else begin
        bus.lsu_rsp_valid = 1'b1;
        bus.lsu_rsp_data  = bus.ram_dout;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter.
// Byte RAM model with registered read address.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  mem_port_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [0:65535];
  logic [15:0] a_r = 16'h0000;
  logic        pl_we = 1'b0;
  logic [15:0] pl_addr = 16'h0000;
  logic [7:0]  pl_data = 8'h00;

  // RAM model: byte writes, word read from registered address.
  always @(posedge clk) begin
    a_r <= bus.ram_addr;
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
    if (pl_we) mem[pl_addr] <= pl_data;
  end

  logic [15:0] a1, a2, a3;
  assign a1 = a_r + 16'd1;
  assign a2 = a_r + 16'd2;
  assign a3 = a_r + 16'd3;
  assign bus.ram_dout = {mem[a3], mem[a2], mem[a1], mem[a_r]};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic pl(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_we = 1'b1;
    pl_addr = a;
    pl_data = d;
    @(posedge clk);
    #1;
    pl_we = 1'b0;
  endtask

  task automatic ifu_read(input logic [15:0] a, input logic [31:0] exp);
    @(negedge clk);
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr = a;
    #1;
    chk("ifu_ready", 32'(bus.ifu_req_ready), 32'd1);
    chk("ifu_ram_addr", 32'(bus.ram_addr), 32'(a));
    @(posedge clk);
    #1;
    bus.ifu_req_valid = 1'b0;
    chk("ifu_rsp_valid", 32'(bus.ifu_rsp_valid), 32'd1);
    chk("ifu_rsp_data", bus.ifu_rsp_data, exp);
    @(posedge clk);
    #1;
    chk("ifu_rsp_pulse", 32'(bus.ifu_rsp_valid), 32'd0);
  endtask

  task automatic lsu_go(input logic we, input logic [1:0] sz,
                        input logic [15:0] a, input logic [31:0] d);
    int n;
    n = 0;
    @(negedge clk);
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_we = we;
    bus.lsu_req_size = sz;
    bus.lsu_req_addr = a;
    bus.lsu_req_wdata = d;
    #1;
    while (!bus.lsu_req_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("lsu_ready", 32'(bus.lsu_req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.lsu_req_valid = 1'b0;
  endtask

  task automatic lsu_read(input logic [15:0] a, input logic [31:0] exp);
    lsu_go(1'b0, SZ_W, a, 32'h0);
    chk("lsu_rd_valid", 32'(bus.lsu_rsp_valid), 32'd1);
    chk("lsu_rd_data", bus.lsu_rsp_data, exp);
    chk("lsu_rd_ifu_quiet", 32'(bus.ifu_rsp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("lsu_rd_pulse", 32'(bus.lsu_rsp_valid), 32'd0);
  endtask

  task automatic lsu_store(input logic [1:0] sz, input logic [15:0] a,
                           input logic [31:0] d, input int nb);
    logic [15:0] ea;
    logic [31:0] sh;
    lsu_go(1'b1, sz, a, d);
    for (int i = 0; i < nb; i++) begin
      ea = a + 16'(i);
      sh = d >> (8 * i);
      chk("st_we", 32'(bus.ram_we), 32'd1);
      chk("st_addr", 32'(bus.ram_addr), 32'(ea));
      chk("st_din", 32'(bus.ram_din), 32'(sh[7:0]));
      chk("st_rsp", 32'(bus.lsu_rsp_valid), (i == nb - 1) ? 32'd1 : 32'd0);
      if (i == nb - 1) chk("st_rsp_data", bus.lsu_rsp_data, 32'd0);
      @(posedge clk);
      #1;
    end
    chk("st_done_we", 32'(bus.ram_we), 32'd0);
    chk("st_done_din", 32'(bus.ram_din), 32'd0);
    chk("st_done_rsp", 32'(bus.lsu_rsp_valid), 32'd0);
  endtask

  initial begin
    int g;
    int ni;
    int nl;
    logic [1:0] seen;
    bus.ifu_req_valid = 1'b1;
    bus.ifu_req_addr = 16'h1234;
    bus.lsu_req_valid = 1'b1;
    bus.lsu_req_we = 1'b1;
    bus.lsu_req_size = SZ_W;
    bus.lsu_req_addr = 16'h0040;
    bus.lsu_req_wdata = 32'h0;

    #12;
    chk("rst_ifu_ready", 32'(bus.ifu_req_ready), 32'd0);
    chk("rst_lsu_ready", 32'(bus.lsu_req_ready), 32'd0);
    chk("rst_ifu_rsp", 32'(bus.ifu_rsp_valid), 32'd0);
    chk("rst_lsu_rsp", 32'(bus.lsu_rsp_valid), 32'd0);
    chk("rst_ram_we", 32'(bus.ram_we), 32'd0);
    chk("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_ram_din", 32'(bus.ram_din), 32'd0);
    chk("rst_ifu_data", bus.ifu_rsp_data, 32'd0);
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("idle_ram_addr", 32'(bus.ram_addr), 32'd0);

    pl(16'h0100, 8'h11);
    pl(16'h0101, 8'h22);
    pl(16'h0102, 8'h33);
    pl(16'h0103, 8'h44);
    pl(16'h000F, 8'h77);
    pl(16'h0010, 8'h00);
    pl(16'h0011, 8'h88);
    pl(16'h001F, 8'h99);
    pl(16'h0022, 8'h66);
    pl(16'h0300, 8'h00);
    pl(16'h0301, 8'h00);
    pl(16'h0302, 8'h00);
    pl(16'h0303, 8'h00);

    ifu_read(16'h0100, 32'h44332211);

    lsu_store(SZ_W, 16'h0200, 32'hDEADBEEF, 4);
    lsu_read(16'h0200, 32'hDEADBEEF);

    lsu_store(SZ_B, 16'h0010, 32'hFFFFFFA5, 1);
    chk("byte_lo", 32'(mem[16'h000F]), 32'h77);
    chk("byte_val", 32'(mem[16'h0010]), 32'hA5);
    chk("byte_hi", 32'(mem[16'h0011]), 32'h88);

    lsu_store(SZ_H, 16'h0020, 32'hFFFF1234, 2);
    chk("half_lo", 32'(mem[16'h001F]), 32'h99);
    chk("half_b0", 32'(mem[16'h0020]), 32'h34);
    chk("half_b1", 32'(mem[16'h0021]), 32'h12);
    chk("half_hi", 32'(mem[16'h0022]), 32'h66);

    bus.ifu_req_addr = 16'h0100;
    bus.lsu_req_we = 1'b0;
    bus.lsu_req_size = SZ_W;
    bus.lsu_req_addr = 16'h0200;
    bus.ifu_req_valid = 1'b1;
    bus.lsu_req_valid = 1'b1;
    g = 0;
    ni = 0;
    nl = 0;
    for (int c = 0; c < 80 && g < 12; c++) begin
      @(negedge clk);
      #1;
      seen = {bus.lsu_req_ready, bus.ifu_req_ready};
      if (seen != 2'b00) begin
        chk("arb_gnt", 32'(seen), (g % 2 == 1) ? 32'd2 : 32'd1);
        @(posedge clk);
        #1;
        chk("arb_rsp", 32'({bus.lsu_rsp_valid, bus.ifu_rsp_valid}),
            32'(seen));
        if (seen[0]) begin
          chk("arb_ifu_data", bus.ifu_rsp_data, 32'h44332211);
          ni++;
        end else begin
          chk("arb_lsu_data", bus.lsu_rsp_data, 32'hDEADBEEF);
          nl++;
        end
        if (ni >= 6) bus.ifu_req_valid = 1'b0;
        if (nl >= 6) bus.lsu_req_valid = 1'b0;
        g++;
      end
    end
    bus.ifu_req_valid = 1'b0;
    bus.lsu_req_valid = 1'b0;
    chk("arb_total", 32'(g), 32'd12);
    chk("arb_ifu_cnt", 32'(ni), 32'd6);

    pl(16'h0000, 8'h5A);
    lsu_store(SZ_H, 16'hFFFF, 32'h0000ABCD, 2);
    chk("wrap_ffff", 32'(mem[16'hFFFF]), 32'hCD);
    chk("wrap_0000", 32'(mem[16'h0000]), 32'hAB);

    lsu_go(1'b1, SZ_W, 16'h0300, 32'hCAFEF00D);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_we", 32'(bus.ram_we), 32'd0);
    chk("mid_rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("mid_rst_din", 32'(bus.ram_din), 32'd0);
    chk("mid_rst_rsp", 32'(bus.lsu_rsp_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_rsp_hold", 32'(bus.lsu_rsp_valid), 32'd0);
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_quiet", 32'({bus.ram_we, bus.lsu_rsp_valid}), 32'd0);
    end
    chk("abort_b0", 32'(mem[16'h0300]), 32'h0D);
    chk("abort_b1", 32'(mem[16'h0301]), 32'hF0);
    chk("abort_b2", 32'(mem[16'h0302]), 32'h00);
    chk("abort_b3", 32'(mem[16'h0303]), 32'h00);

    ifu_read(16'h0100, 32'h44332211);
    lsu_read(16'h0300, 32'h0000F00D);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
